// File: rtl/i2s_dac_tx_if.sv
// Stereo sample handshake between an audio source and the WM8731 I2S transmitter.
// The source drives valid and both channels; the transmitter answers with ready.
interface i2s_dac_tx_if #(
   parameter int DATA_W = 24
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_left;
   logic [DATA_W-1:0] in_right;

   modport master (output in_valid, output in_left, output in_right, input in_ready);
   modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC (codec as slave): generates XCK, BCLK, DACLRCK and
// DACDAT from clk and streams stereo samples taken through a one-entry holding register.
module i2s_dac_tx #(
   parameter int DATA_W   = 24,
   parameter int XCK_DIV  = 4,
   parameter int BCLK_DIV = 16,
   parameter int SLOT_W   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_done,
   i2s_dac_tx_if.slave smp,
   output logic        aud_xck,
   output logic        aud_bclk,
   output logic        aud_daclrck,
   output logic        aud_dacdat,
   output logic        frame_start,
   output logic        underrun
);
   localparam int XCK_W = $clog2(XCK_DIV);
   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int BIT_W = $clog2(2 * SLOT_W);
   localparam int EXT_W = 2 ** BIT_W;

   localparam logic [XCK_W-1:0] XCK_LAST = XCK_W'(XCK_DIV - 1);
   localparam logic [XCK_W-1:0] XCK_HALF = XCK_W'(XCK_DIV / 2);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
   localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_W);
   localparam logic [BIT_W-1:0] DATA_TOP = BIT_W'(DATA_W);

   typedef enum logic {IDLE, RUN} state_e;

   state_e            state_q, state_d;
   logic [XCK_W-1:0]  xck_cnt_q, xck_cnt_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
   logic              xck_q, xck_d, bclk_q, bclk_d, lrck_q, lrck_d, dacdat_q, dacdat_d;
   logic              frame_start_q, frame_start_d, in_ready_q, in_ready_d;

   logic              run_d;
   logic              in_fire;
   logic [BIT_W-1:0]  slot;
   logic [BIT_W-1:0]  sel_idx;
   logic [EXT_W-1:0]  ch_ext;

   always_comb begin
      // NOTE: every value written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      xck_cnt_d   = xck_cnt_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      act_l_d     = act_l_q;
      act_r_d     = act_r_q;
      dacdat_d    = dacdat_q;
      in_fire     = smp.in_valid && in_ready_q;

      case (state_q)
         IDLE: begin
            xck_cnt_d   = '0;
            div_cnt_d   = '0;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
            if (cfg_done) state_d = RUN;
         end
         RUN: begin
            if (!cfg_done) begin
               state_d     = IDLE;
               xck_cnt_d   = '0;
               div_cnt_d   = '0;
               bit_cnt_d   = '0;
               hold_full_d = 1'b0;
            end else begin
               xck_cnt_d = (xck_cnt_q == XCK_LAST) ? '0 : xck_cnt_q + 1'b1;
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_d = '0;
                  bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
               // frame_start_q marks the cycle where both counters sit at zero: load a frame.
               if (frame_start_q) begin
                  if (hold_full_q) begin
                     act_l_d     = hold_l_q;
                     act_r_d     = hold_r_q;
                     hold_full_d = 1'b0;
                  end else if (in_fire) begin
                     act_l_d = smp.in_left;
                     act_r_d = smp.in_right;
                  end else begin
                     act_l_d = '0;
                     act_r_d = '0;
                  end
               end else if (in_fire) begin
                  hold_l_d    = smp.in_left;
                  hold_r_d    = smp.in_right;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from next-state values so the registers line up with the counters.
      run_d         = (state_d == RUN);
      xck_d         = run_d && (xck_cnt_d >= XCK_HALF);
      bclk_d        = run_d && (div_cnt_d >= DIV_HALF);
      lrck_d        = run_d && (bit_cnt_d >= SLOT);
      frame_start_d = run_d && (bit_cnt_d == '0) && (div_cnt_d == '0);
      in_ready_d    = run_d && !hold_full_d;

      slot    = lrck_d ? bit_cnt_d - SLOT : bit_cnt_d;
      ch_ext  = lrck_d ? EXT_W'(act_r_d) : EXT_W'(act_l_d);
      sel_idx = DATA_TOP - slot;
      if (!run_d) begin
         dacdat_d = 1'b0;
      end else if (div_cnt_d == '0) begin
         dacdat_d = (slot != '0) && (slot <= DATA_TOP) && ch_ext[sel_idx];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q       <= IDLE;
         xck_cnt_q     <= '0;
         div_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         hold_full_q   <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         act_l_q       <= '0;
         act_r_q       <= '0;
         xck_q         <= 1'b0;
         bclk_q        <= 1'b0;
         lrck_q        <= 1'b0;
         dacdat_q      <= 1'b0;
         frame_start_q <= 1'b0;
         in_ready_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         xck_cnt_q     <= xck_cnt_d;
         div_cnt_q     <= div_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         hold_full_q   <= hold_full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         act_l_q       <= act_l_d;
         act_r_q       <= act_r_d;
         xck_q         <= xck_d;
         bclk_q        <= bclk_d;
         lrck_q        <= lrck_d;
         dacdat_q      <= dacdat_d;
         frame_start_q <= frame_start_d;
         in_ready_q    <= in_ready_d;
      end
   end

   assign aud_xck      = xck_q;
   assign aud_bclk     = bclk_q;
   assign aud_daclrck  = lrck_q;
   assign aud_dacdat   = dacdat_q;
   assign frame_start  = frame_start_q;
   assign smp.in_ready = in_ready_q;
   // Underrun depends on this cycle's handshake, since a bypassed sample still counts.
   assign underrun     = frame_start_q && !hold_full_q && !in_fire;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: idle behaviour, clock ratios, frame contents,
// underrun, back-pressured streaming, cfg_done drop and mid-frame reset.
module tb_i2s_dac_tx;
   localparam int DATA_W = 24;

   logic clk = 1'b0;
   logic rst_n;
   logic cfg_done;
   logic aud_xck, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun;
   logic [6:0] all_outs;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2047:0] xck_t, bclk_t, lrck_t, dac_t, fs_t, ur_t;

   i2s_dac_tx_if #(.DATA_W(DATA_W)) smp ();

   i2s_dac_tx #(
      .DATA_W(DATA_W), .XCK_DIV(4), .BCLK_DIV(16), .SLOT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .smp(smp),
      .aud_xck(aud_xck), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
      .aud_dacdat(aud_dacdat), .frame_start(frame_start), .underrun(underrun)
   );

   always #10 clk = ~clk;

   assign all_outs = {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, smp.in_ready};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int first_diff(input logic [2047:0] got, input logic [2047:0] want);
      for (int i = 0; i < 2048; i++) if (got[i] !== want[i]) return i;
      return -1;
   endfunction

   task automatic wait_frame(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (frame_start === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cfg_done = 1'b0;
      smp.in_valid = 1'b0;
      smp.in_left = '0;
      smp.in_right = '0;
      repeat (3) step();
      n_checks++;
      if (all_outs !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want %b", all_outs, 7'b0);
      end
   endtask

   task automatic test_idle();
      logic [6:0] seen;
      seen = '0;
      rst_n = 1'b1;
      smp.in_valid = 1'b1;
      smp.in_left = 24'h111111;
      smp.in_right = 24'h222222;
      for (int i = 0; i < 5000; i++) begin
         step();
         seen = seen | all_outs;
      end
      smp.in_valid = 1'b0;
      n_checks++;
      if (seen !== 7'b0) begin
         n_fail++;
         $display("FAIL idle_outputs: OR of outputs over 5000 clk got %b want %b", seen, 7'b0);
      end
   endtask

   task automatic test_run_trace();
      logic [2047:0] xck_e, bclk_e, lrck_e, fs_e, ur_e;
      logic [63:0]   w;
      logic [63:0]   want [2];
      logic          rdy0;
      int            d;
      int            edges_off;

      smp.in_valid = 1'b1;
      smp.in_left  = 24'hA5A5A5;
      smp.in_right = 24'h5A5A5A;
      cfg_done     = 1'b1;
      rdy0         = 1'b0;
      for (int n = 0; n < 2048; n++) begin
         step();
         if (n == 1) smp.in_valid = 1'b0;
         if (n == 0) rdy0 = smp.in_ready;
         xck_t[n]  = aud_xck;
         bclk_t[n] = aud_bclk;
         lrck_t[n] = aud_daclrck;
         dac_t[n]  = aud_dacdat;
         fs_t[n]   = frame_start;
         ur_t[n]   = underrun;
      end

      for (int n = 0; n < 2048; n++) begin
         xck_e[n]  = ((n % 4) >= 2);
         bclk_e[n] = ((n % 16) >= 8);
         lrck_e[n] = (((n / 16) % 64) >= 32);
         fs_e[n]   = ((n % 1024) == 0);
         ur_e[n]   = (n == 1024);
      end

      n_checks++;
      if (rdy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL first_run_ready: got %b want 1", rdy0);
      end
      n_checks++;
      if (xck_t !== xck_e) begin
         n_fail++; d = first_diff(xck_t, xck_e);
         $display("FAIL xck_period: cycle %0d got %b want %b", d, xck_t[d], xck_e[d]);
      end
      n_checks++;
      if (bclk_t !== bclk_e) begin
         n_fail++; d = first_diff(bclk_t, bclk_e);
         $display("FAIL bclk_period: cycle %0d got %b want %b", d, bclk_t[d], bclk_e[d]);
      end
      n_checks++;
      if (lrck_t !== lrck_e) begin
         n_fail++; d = first_diff(lrck_t, lrck_e);
         $display("FAIL lrck_period: cycle %0d got %b want %b", d, lrck_t[d], lrck_e[d]);
      end
      n_checks++;
      if (fs_t !== fs_e) begin
         n_fail++; d = first_diff(fs_t, fs_e);
         $display("FAIL frame_start_trace: cycle %0d got %b want %b", d, fs_t[d], fs_e[d]);
      end
      n_checks++;
      if (ur_t !== ur_e) begin
         n_fail++; d = first_diff(ur_t, ur_e);
         $display("FAIL underrun_trace: cycle %0d got %b want %b", d, ur_t[d], ur_e[d]);
      end

      n_checks++;
      if (dac_t[16] !== 1'b1 || dac_t[15] !== 1'b0) begin
         n_fail++;
         $display("FAIL msb_latency: dacdat[15]=%b dacdat[16]=%b want 0 then 1", dac_t[15], dac_t[16]);
      end

      edges_off = 0;
      for (int n = 1; n < 2048; n++)
         if ((n % 16) != 0 && dac_t[n] !== dac_t[n-1]) edges_off++;
      n_checks++;
      if (edges_off !== 0) begin
         n_fail++;
         $display("FAIL dacdat_stable: %0d changes away from bclk falling edge, want 0", edges_off);
      end

      want[0] = {1'b0, 24'hA5A5A5, 7'd0, 1'b0, 24'h5A5A5A, 7'd0};
      want[1] = 64'd0;
      for (int f = 0; f < 2; f++) begin
         w = '0;
         for (int b = 0; b < 64; b++) w[63-b] = dac_t[f*1024 + b*16 + 8];
         n_checks++;
         if (w !== want[f]) begin
            n_fail++;
            $display("FAIL frame%0d_data: got %h want %h", f, w, want[f]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] q_l [$];
      logic [23:0] q_r [$];
      logic [63:0] word, want;
      logic [23:0] el, er;
      logic        fire, prev_bclk;
      bit          ok, collecting;
      int          k, frames, accepts, ur, budget;

      k = 0; frames = 0; accepts = 0; ur = 0; collecting = 1'b0; word = '0;
      wait_frame(2000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_sync: frame_start got 0 want 1 within 2000 clk");
      end
      step();
      smp.in_valid = 1'b1;
      smp.in_left  = 24'h123400;
      smp.in_right = 24'hFEDC00;
      prev_bclk = aud_bclk;
      for (budget = 0; budget < 6000 && frames < 5; budget++) begin
         fire = smp.in_valid && smp.in_ready;
         step();
         if (fire) begin
            q_l.push_back(smp.in_left);
            q_r.push_back(smp.in_right);
            accepts++;
            k++;
            smp.in_left  = 24'h123400 + 24'(k);
            smp.in_right = 24'hFEDC00 - 24'(k);
         end
         if (aud_bclk && !prev_bclk) word = {word[62:0], aud_dacdat};
         prev_bclk = aud_bclk;
         if (frame_start) begin
            if (underrun) ur++;
            if (collecting) begin
               el = (q_l.size() > 0) ? q_l.pop_front() : 24'hXXXXXX;
               er = (q_r.size() > 0) ? q_r.pop_front() : 24'hXXXXXX;
               want = {1'b0, el, 7'd0, 1'b0, er, 7'd0};
               n_checks++;
               if (word !== want) begin
                  n_fail++;
                  $display("FAIL b2b_frame%0d: got %h want %h", frames, word, want);
               end
               n_checks++;
               if (accepts !== 1) begin
                  n_fail++;
                  $display("FAIL b2b_accepts%0d: got %0d accepts in frame want 1", frames, accepts);
               end
            end
            collecting = 1'b1;
            accepts = 0;
            word = '0;
            frames++;
         end
      end
      smp.in_valid = 1'b0;
      n_checks++;
      if (frames !== 5) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d frames want 5", frames);
      end
      n_checks++;
      if (ur !== 0) begin
         n_fail++;
         $display("FAIL b2b_underrun: got %0d underruns want 0", ur);
      end
   endtask

   task automatic test_cfg_drop();
      step();
      n_checks++;
      if (smp.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_ready_empty: got %b want 1", smp.in_ready);
      end
      smp.in_valid = 1'b1;
      smp.in_left  = 24'hABCDEF;
      smp.in_right = 24'h13579B;
      step();
      smp.in_valid = 1'b0;
      n_checks++;
      if (smp.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_ready_full: got %b want 0", smp.in_ready);
      end
      cfg_done = 1'b0;
      step();
      n_checks++;
      if (all_outs !== 7'b0) begin
         n_fail++;
         $display("FAIL drop_outputs: got %b want %b", all_outs, 7'b0);
      end
      repeat (20) step();
      cfg_done = 1'b1;
      step();
      n_checks++;
      if ({frame_start, underrun, smp.in_ready} !== 3'b111) begin
         n_fail++;
         $display("FAIL drop_restart: {frame_start,underrun,in_ready} got %b want 111",
                  {frame_start, underrun, smp.in_ready});
      end
   endtask

   task automatic test_reset_mid();
      repeat (645) step();
      n_checks++;
      if (aud_daclrck !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_slot: daclrck at bit 40 got %b want 1", aud_daclrck);
      end
      rst_n = 1'b0;
      step();
      n_checks++;
      if (all_outs !== 7'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got %b want %b", all_outs, 7'b0);
      end
      repeat (3) step();
      n_checks++;
      if (all_outs !== 7'b0) begin
         n_fail++;
         $display("FAIL mid_reset_hold: got %b want %b", all_outs, 7'b0);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({frame_start, underrun, aud_xck, aud_bclk, aud_daclrck} !== 5'b11000) begin
         n_fail++;
         $display("FAIL mid_restart: {fs,ur,xck,bclk,lrck} got %b want 11000",
                  {frame_start, underrun, aud_xck, aud_bclk, aud_daclrck});
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_run_trace();
      test_back_to_back();
      test_cfg_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
